// File: rtl/quad_decoder_pkg.sv
// rtl/quad_decoder_pkg.sv - Gray state encodings, direction constants and decode helper for quad_decoder
package quad_decoder_pkg;

    typedef enum logic [1:0] {
        S0 = 2'b00,
        S1 = 2'b01,
        S2 = 2'b11,
        S3 = 2'b10
    } qstate_t;

    localparam logic DIR_UP   = 1'b1;
    localparam logic DIR_DOWN = 1'b0;

    // Position of a Gray state around the S0..S3 cycle; the modulo-4 difference
    // of two positions gives 1 for an up step, 3 for down and 2 for a jump.
    function automatic logic [1:0] gray_pos(input logic [1:0] s);
        case (s)
            S0:      return 2'd0;
            S1:      return 2'd1;
            S2:      return 2'd2;
            default: return 2'd3;
        endcase
    endfunction

endpackage

// File: rtl/quad_glitch_filter.sv
// rtl/quad_glitch_filter.sv - per-channel glitch filter, built only with QDEC_FILTER_EN
`ifdef QDEC_FILTER_EN
module quad_glitch_filter #(
    parameter int FILTER_LEN = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic i_d,
    output logic o_q
);

    localparam logic [3:0] LAST = 4'(FILTER_LEN - 1);

    logic [3:0] r_cnt;
    logic       r_q;

    // Count consecutive samples that disagree with the output; adopt the new
    // level on the FILTER_LEN-th one, any agreeing sample restarts the count.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt <= 4'd0;
            r_q   <= 1'b0;
        end else if (i_d == r_q) begin
            r_cnt <= 4'd0;
        end else if (r_cnt == LAST) begin
            r_q   <= i_d;
            r_cnt <= 4'd0;
        end else begin
            r_cnt <= r_cnt + 4'd1;
        end
    end

    assign o_q = r_q;

endmodule
`endif

// File: rtl/quad_decoder.sv
// rtl/quad_decoder.sv - quadrature decoder with saturating position counter; optional filter via QDEC_FILTER_EN
module quad_decoder
    import quad_decoder_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int FILTER_LEN  = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       qa,
    input  logic       qb,
    input  logic       load,
    input  logic [7:0] load_data,
    input  logic [7:0] limit,
    output logic [7:0] count,
    output logic       dir,
    output logic       step,
    output logic       err
);

    logic [SYNC_STAGES-1:0] r_sync_a;
    logic [SYNC_STAGES-1:0] r_sync_b;
    logic                   w_a;
    logic                   w_b;
    logic [1:0]             w_cur;
    logic [1:0]             w_delta;

    logic [1:0] r_prev;
    logic       r_primed;
    logic [7:0] r_count;
    logic       r_dir;
    logic       r_step;
    logic       r_err;

    // Bring both asynchronous channels into the clock domain.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_sync_a <= '0;
            r_sync_b <= '0;
        end else begin
            r_sync_a <= {r_sync_a[SYNC_STAGES-2:0], qa};
            r_sync_b <= {r_sync_b[SYNC_STAGES-2:0], qb};
        end
    end

`ifdef QDEC_FILTER_EN
    quad_glitch_filter #(.FILTER_LEN(FILTER_LEN)) u_filt_a (
        .clk   (clk),
        .reset (reset),
        .i_d   (r_sync_a[SYNC_STAGES-1]),
        .o_q   (w_a)
    );

    quad_glitch_filter #(.FILTER_LEN(FILTER_LEN)) u_filt_b (
        .clk   (clk),
        .reset (reset),
        .i_d   (r_sync_b[SYNC_STAGES-1]),
        .o_q   (w_b)
    );
`else
    assign w_a = r_sync_a[SYNC_STAGES-1];
    assign w_b = r_sync_b[SYNC_STAGES-1];
`endif

    assign w_cur   = {w_a, w_b};
    assign w_delta = gray_pos(w_cur) - gray_pos(r_prev);

    // Decode the state change, run the saturating counter and flag jumps;
    // a load overrides the count and clears the error but not step/dir.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_prev   <= S0;
            r_primed <= 1'b0;
            r_count  <= 8'd0;
            r_dir    <= DIR_DOWN;
            r_step   <= 1'b0;
            r_err    <= 1'b0;
        end else begin
            r_step <= 1'b0;
            r_prev <= w_cur;
            if (!r_primed) begin
                r_primed <= 1'b1;
            end else if (w_delta == 2'd1) begin
                r_step <= 1'b1;
                r_dir  <= DIR_UP;
                if (r_count < limit) begin
                    r_count <= r_count + 8'd1;
                end
            end else if (w_delta == 2'd3) begin
                r_step <= 1'b1;
                r_dir  <= DIR_DOWN;
                if (r_count != 8'd0) begin
                    r_count <= r_count - 8'd1;
                end
            end else if (w_delta == 2'd2) begin
                r_err <= 1'b1;
            end
            if (load) begin
                r_count <= load_data;
                r_err   <= 1'b0;
            end
        end
    end

    assign count = r_count;
    assign dir   = r_dir;
    assign step  = r_step;
    assign err   = r_err;

endmodule

// File: tb/tb_quad_decoder.sv
// tb/tb_quad_decoder.sv - self-checking bench for quad_decoder (table, corner sequences, random vs model)
module tb_quad_decoder;

    localparam int N = 2;
    localparam int F = 4;
`ifdef QDEC_FILTER_EN
    localparam int LAT      = N + F + 1;
    localparam int HOLD_MIN = F;
`else
    localparam int LAT      = N + 1;
    localparam int HOLD_MIN = 1;
`endif
    localparam int OFS = 16;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       qa = 1'b0;
    logic       qb = 1'b0;
    logic       load = 1'b0;
    logic [7:0] load_data = 8'd0;
    logic [7:0] limit = 8'd10;
    logic [7:0] count;
    logic       dir;
    logic       step;
    logic       err;

    quad_decoder #(.SYNC_STAGES(N), .FILTER_LEN(F)) dut (
        .clk       (clk),
        .reset     (reset),
        .qa        (qa),
        .qb        (qb),
        .load      (load),
        .load_data (load_data),
        .limit     (limit),
        .count     (count),
        .dir       (dir),
        .step      (step),
        .err       (err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int passed = 0;
    int pulses = 0;

    typedef struct {
        logic [1:0] st;
        logic       ld;
        logic [7:0] ld_data;
        int         e_count;
        logic       e_dir;
        int         e_pulses;
        logic       e_err;
    } vec_t;

    vec_t tbl[$];

    // Gray code of each position around the cycle: S0, S1, S2, S3.
    logic [1:0] gray_of [4] = '{2'b00, 2'b01, 2'b11, 2'b10};

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        if (step) pulses++;
    endtask

    task automatic drive(input logic [1:0] s);
        qa = s[1];
        qb = s[0];
    endtask

    function automatic vec_t mk(input logic [1:0] st, input logic ld, input logic [7:0] ldd,
                                input int c, input logic d, input int p, input logic e);
        vec_t v;
        v.st = st; v.ld = ld; v.ld_data = ldd;
        v.e_count = c; v.e_dir = d; v.e_pulses = p; v.e_err = e;
        return v;
    endfunction

    int first_k;
    int hist [0:4095];
    int m_count;
    int m_dir;
    int m_err;
    int m_step;
    int cur_p;
    int hold;

    initial begin
        // Four forward cycles starting from S0 with limit 10: count saturates at 10.
        for (int k = 1; k <= 16; k++)
            tbl.push_back(mk(gray_of[k % 4], 1'b0, 8'd0, (k < 10) ? k : 10, 1'b1, 1, 1'b0));
        tbl.push_back(mk(2'b00, 1'b1, 8'd5,  5, 1'b1, 0, 1'b0));
        tbl.push_back(mk(2'b10, 1'b0, 8'd0,  4, 1'b0, 1, 1'b0));
        tbl.push_back(mk(2'b11, 1'b0, 8'd0,  3, 1'b0, 1, 1'b0));
        tbl.push_back(mk(2'b01, 1'b0, 8'd0,  2, 1'b0, 1, 1'b0));
        tbl.push_back(mk(2'b00, 1'b0, 8'd0,  1, 1'b0, 1, 1'b0));
        tbl.push_back(mk(2'b10, 1'b0, 8'd0,  0, 1'b0, 1, 1'b0));
        tbl.push_back(mk(2'b11, 1'b0, 8'd0,  0, 1'b0, 1, 1'b0));
        tbl.push_back(mk(2'b01, 1'b0, 8'd0,  0, 1'b0, 1, 1'b0));
        tbl.push_back(mk(2'b10, 1'b0, 8'd0,  0, 1'b0, 0, 1'b1));
        tbl.push_back(mk(2'b10, 1'b1, 8'd7,  7, 1'b0, 0, 1'b0));
        tbl.push_back(mk(2'b00, 1'b0, 8'd0,  8, 1'b1, 1, 1'b0));
        tbl.push_back(mk(2'b00, 1'b1, 8'd12, 12, 1'b1, 0, 1'b0));
        tbl.push_back(mk(2'b01, 1'b0, 8'd0,  12, 1'b1, 1, 1'b0));
        tbl.push_back(mk(2'b00, 1'b0, 8'd0,  11, 1'b0, 1, 1'b0));

        // Reset state.
        repeat (3) tick();
        chk("reset_count", count, 0);
        chk("reset_dir", dir, 0);
        chk("reset_step", step, 0);
        chk("reset_err", err, 0);
        reset = 1'b0;
        tick();
        chk("prime_step", step, 0);
        chk("prime_err", err, 0);
        repeat (LAT + 2) tick();

        // Table-driven vectors.
        foreach (tbl[i]) begin
            pulses = 0;
            drive(tbl[i].st);
            load = tbl[i].ld;
            load_data = tbl[i].ld_data;
            tick();
            load = 1'b0;
            repeat (LAT + 2) tick();
            chk($sformatf("tbl%0d_count", i), count, tbl[i].e_count);
            chk($sformatf("tbl%0d_dir", i), dir, tbl[i].e_dir);
            chk($sformatf("tbl%0d_pulses", i), pulses, tbl[i].e_pulses);
            chk($sformatf("tbl%0d_err", i), err, tbl[i].e_err);
        end

        // Latency from input edge to step; count 11 is above limit so it holds.
        drive(2'b01);
        first_k = -1;
        for (int k = 1; k <= LAT + 3; k++) begin
            tick();
            if (step && first_k < 0) first_k = k;
        end
        chk("latency", first_k, LAT);
        chk("latency_count_hold", count, 11);

        // Load coinciding with a step: step and dir still update, count takes load_data.
        drive(2'b11);
        repeat (LAT - 1) tick();
        load = 1'b1;
        load_data = 8'd33;
        tick();
        load = 1'b0;
        chk("coload_step", step, 1);
        chk("coload_count", count, 33);
        chk("coload_dir", dir, 1);
        tick();
        chk("coload_step_one_cycle", step, 0);

`ifdef QDEC_FILTER_EN
        // Two-cycle glitch is rejected, a sustained level passes after N+5 cycles.
        qa = 1'b0;
        repeat (2) tick();
        qa = 1'b1;
        pulses = 0;
        repeat (12) tick();
        chk("glitch_pulses", pulses, 0);
        chk("glitch_count", count, 33);
        qa = 1'b0;
        first_k = -1;
        for (int k = 1; k <= LAT + 3; k++) begin
            tick();
            if (step && first_k < 0) first_k = k;
        end
        chk("filter_latency", first_k, N + 5);
        chk("filter_count", count, 32);
        chk("filter_dir", dir, 0);
        qa = 1'b1;
        repeat (LAT + 2) tick();
`endif

        // Reset mid-sequence with inputs at S2; a pending S3 is discarded.
        drive(2'b10);
        tick();
        reset = 1'b1;
        drive(2'b11);
        repeat (3) tick();
        chk("midreset_count", count, 0);
        reset = 1'b0;
        tick();
        chk("postreset_count", count, 0);
        chk("postreset_step", step, 0);
        chk("postreset_err", err, 0);
        repeat (LAT + 2) tick();
        pulses = 0;
        drive(2'b10);
        repeat (LAT + 2) tick();
        chk("postreset_up_pulses", pulses, 1);
        chk("postreset_up_dir", dir, 1);
        chk("postreset_up_count", count, 1);

        // Randomized phase against a position-arithmetic reference model.
        load = 1'b1;
        load_data = 8'd4;
        tick();
        load = 1'b0;
        repeat (LAT + 2) tick();
        m_count = 4; m_dir = 1; m_err = 0;
        cur_p = 3;
        for (int k = 0; k <= OFS; k++) hist[k] = cur_p;
        hold = HOLD_MIN;
        for (int j = 1; j <= 600; j++) begin
            int d;
            tick();
            d = (hist[j - LAT + OFS] - hist[j - LAT - 1 + OFS] + 4) % 4;
            m_step = 0;
            if (d == 1) begin
                m_step = 1; m_dir = 1;
                if (m_count < int'(limit)) m_count++;
            end else if (d == 3) begin
                m_step = 1; m_dir = 0;
                if (m_count > 0) m_count--;
            end else if (d == 2) begin
                m_err = 1;
            end
            if (load) begin
                m_count = int'(load_data);
                m_err = 0;
            end
            chk($sformatf("rnd%0d_count", j), count, m_count);
            chk($sformatf("rnd%0d_dir", j), dir, m_dir);
            chk($sformatf("rnd%0d_step", j), step, m_step);
            chk($sformatf("rnd%0d_err", j), err, m_err);

            hold--;
            if (hold == 0) begin
                int r;
                r = $urandom_range(0, 9);
                if (r < 4) cur_p = (cur_p + 1) % 4;
                else if (r < 8) cur_p = (cur_p + 3) % 4;
                else if (r == 8) cur_p = (cur_p + 2) % 4;
                hold = HOLD_MIN + $urandom_range(0, 2);
            end
            hist[j + OFS] = cur_p;
            drive(gray_of[cur_p]);
            load = ($urandom_range(0, 19) == 0);
            load_data = 8'($urandom_range(0, 15));
            if ($urandom_range(0, 49) == 0) limit = 8'($urandom_range(0, 12));
        end

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/quad_decoder.md
QUAD_DECODER -- requirements
Module: quad_decoder

Interface
REQ-001 Parameter SYNC_STAGES, default 2: input synchronizer depth per channel (>=2).
REQ-002 Parameter FILTER_LEN, default 4: stable-sample count for the glitch filter (2..15); only used with QDEC_FILTER_EN.
REQ-003 clk  input  1  clock; all logic on rising edge.
REQ-004 reset  input  1  reset, synchronous, active-high.
REQ-005 qa  input  1  quadrature channel A, asynchronous.
REQ-006 qb  input  1  quadrature channel B, asynchronous.
REQ-007 load  input  1  load position from load_data.
REQ-008 load_data  input  8  position value to load.
REQ-009 limit  input  8  upper count bound, unsigned.
REQ-010 count  output  8  current position, unsigned.
REQ-011 dir  output  1  direction of last accepted step; 1 = up, 0 = down.
REQ-012 step  output  1  one-cycle strobe per accepted transition.
REQ-013 err  output  1  sticky illegal-transition flag.

Function
REQ-014 qa, qb SHALL each pass through SYNC_STAGES flops before any other use.
REQ-015 Synchronized pair {A,B} SHALL be decoded as Gray states S0=00, S1=01, S2=11, S3=10.
REQ-016 Transitions S0->S1->S2->S3->S0 SHALL be up steps; the reverse order SHALL be down steps.
REQ-017 An unchanged state SHALL produce no step and no error.
REQ-018 A two-bit change (S0<->S2, S1<->S3) SHALL set err, produce no step, leave count and dir unchanged, and update the stored previous state.
REQ-019 Each accepted step SHALL pulse step high for exactly one cycle and update dir in the same cycle.
REQ-020 Up step: count increments if count < limit, else holds (saturate at limit).
REQ-021 Down step: count decrements if count > 0, else holds (saturate at 0).
REQ-022 step SHALL still pulse on a saturated step; only count holds.
REQ-023 load SHALL set count = load_data next cycle and clear err; it takes priority over a coincident step (step still pulses, dir still updates, count = load_data).
REQ-024 load_data > limit SHALL be loaded unmodified; subsequent up steps then hold.
REQ-025 Latency without filter: qa edge to step high SHALL be SYNC_STAGES+1 clk cycles.
REQ-026 A primed flag SHALL suppress decode for the first cycle after reset: the synchronized state is captured as previous state, with no step and no err.

Reset
REQ-027 While reset is high: count=0, dir=0, step=0, err=0, primed=0, synchronizer and filter flops=0.
REQ-028 Reset asserted mid-sequence SHALL discard all pending state; decode resumes per REQ-026.

Configuration
REQ-029 Macro QDEC_FILTER_EN defined: each synchronized channel SHALL be accepted only after FILTER_LEN consecutive identical samples; pulses shorter than FILTER_LEN cycles SHALL be ignored; latency becomes SYNC_STAGES+FILTER_LEN+1.
REQ-030 QDEC_FILTER_EN undefined: no filter logic SHALL be present; synchronized values feed the decoder directly; FILTER_LEN is unused.

Structure
REQ-031 Package quad_decoder_pkg SHALL hold the Gray state encodings S0..S3 and the direction constants DIR_UP=1, DIR_DOWN=0.
REQ-032 Sub-module quad_glitch_filter (one channel, stable counter plus output flop) SHALL be instanced once per channel under QDEC_FILTER_EN.

Verification
REQ-033 Reset, limit=10, four forward cycles S0->S1->S2->S3->S0 (16 steps) -> 16 step pulses, dir=1, count saturates at 10.
REQ-034 load=1 with load_data=5, then 3 reverse transitions -> count 5,4,3,2; dir=0; err=0.
REQ-035 From count=1, 3 down steps -> count 0 and holds; 3 step pulses.
REQ-036 Jump S0->S2 -> err=1, no step, count unchanged; later load -> err=0.
REQ-037 Filter enabled, FILTER_LEN=4: 2-cycle pulse on qa -> no step; 6-cycle level change -> one step after SYNC_STAGES+5 cycles.
REQ-038 Reset asserted between two transitions with inputs at S2 -> after release count=0, no step, no err on first cycle, next valid transition S2->S3 gives an up step.
